div_ctrl: RTL and testbench
===========================

# div_ctrl

Initiator side of the iterative divider's request/finish interface, sitting in the EX stage beside the ALU. It issues DIV/DIVU operands to the divider and stalls the instruction in EX until the result returns. It buffers quotient/remainder and commits them to architectural HI/LO only when the instruction leaves EX, cancelling in-flight divisions on pipeline flush. It also owns the HI/LO registers, including MTHI/MTLO writes and read ports.

## Interface
Parameters: none.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  EX holds a DIV/DIVU instruction
- req_sign  in  1  1 = DIV (signed), 0 = DIVU
- req_a, req_b  in  32  dividend, divisor (held stable while req_valid)
- req_advance  in  1  EX instruction moves to MEM at this edge
- flush  in  1  exception/ERET flush of EX; kills current request
- mthi_we, mtlo_we  in  1  MTHI/MTLO write strobes
- mt_wdata  in  32  MTHI/MTLO data
- div_stall  out  1  hold EX; division not yet complete
- div_en  out  1  one-cycle start pulse to divider
- div_sign  out  1  = req_sign
- div_a, div_b  out  32  = req_a, req_b
- div_cancel  out  1  abort divider iteration
- div_q, div_r  in  32  quotient/remainder, valid in div_finish cycle
- div_working  in  1  divider iterating (monitored only)
- div_finish  in  1  one-cycle completion pulse
- hi, lo  out  32  architectural HI/LO

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: div_en = req_valid && !flush. When div_en is high, go to BUSY.
- BUSY: wait for div_finish.
  - On flush: div_cancel = 1, go to IDLE, nothing latched.
  - On div_finish && !flush: latch div_q→res_q and div_r→res_r, go to DONE.
  - If flush and div_finish occur together, flush wins: cancel, IDLE, no latch.
- DONE: result held.
  - On req_advance && !flush: commit hi←res_r, lo←res_q, go to IDLE.
  - On flush: go to IDLE, no commit.
- div_stall = req_valid && state != DONE. It is 0 in DONE, so downstream holds are absorbed without reissue.
- div_cancel = flush && state == BUSY. It is combinational and never asserted outside BUSY.
- MTHI/MTLO: hi←mt_wdata on mthi_we; lo←mt_wdata on mtlo_we.
  - These are ignored when flush is high.
  - A DONE commit in the same cycle has priority over mthi/mtlo.
- Divide by zero: the request runs normally and the divider's result is committed; no trap.
- Reset values: state IDLE, hi = lo = res_q = res_r = 0. div_en, div_cancel and div_stall are all 0 while req_valid is low.
- Reset mid-operation returns to IDLE immediately. The divider is reset by the same event, so no cancel is needed.

## Timing
- Cycle 0 (IDLE, req_valid): div_en = 1, div_stall = 1.
- The divider asserts div_finish in cycle 17. div_stall stays 1 through cycle 17.
- Cycle 18: state DONE, div_stall = 0. With req_advance in cycle 18, hi/lo are updated and visible in cycle 19.
- Minimum EX occupancy for a division: 19 cycles (0–18).
- Back-to-back: a second DIV entering EX at cycle 19 sees IDLE and pulses div_en in cycle 19. There is no dead cycle.
- div_en is never asserted in BUSY or DONE. At most one division is outstanding.
- Flush in cycle k of BUSY: div_cancel = 1 in cycle k, IDLE in cycle k+1. A new request may pulse div_en in cycle k+1.
- hi/lo change only at a DONE commit or an MT write, never in the div_finish cycle.

## Test plan
- DIVU 100/7, req_advance tied 1: div_en in cycle 0, div_stall cycles 0–17, then hi = 2, lo = 14 in cycle 19.
- DIV 0xFFFFFFF9 / 2 (−7/2): lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Also DIVU of the same operands: lo = 0x7FFFFFFC, hi = 1.
- Flush in cycle 5 of BUSY: div_cancel high one cycle, hi/lo unchanged (preloaded 0xA5A5A5A5 via MT). A following DIVU 9/3 gives lo = 3, hi = 0.
- Downstream hold: req_advance low for 4 cycles after div_finish. Check div_stall = 0, hi/lo unchanged, no second div_en; commit on the advance edge.
- Flush in DONE, and flush coincident with div_finish: no commit, IDLE next cycle. MTHI with a coincident DONE commit: the commit value wins.
- Assert reset in cycle 8 of BUSY: hi = lo = 0, state IDLE. No div_en until req_valid is reasserted after reset deasserts.

Source files
------------

// File: rtl/div_ctrl.sv
// Issues DIV/DIVU to the iterative divider, stalls EX until it finishes, owns HI/LO.
// Latency: 19 cycles minimum in EX; backpressure: the result is held in DONE until req_advance, flush discards it.
module div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_sign,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_advance,
    input  logic        flush,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_wdata,
    output logic        div_stall,
    output logic        div_en,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_cancel,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_working,
    input  logic        div_finish,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] res_q;
    logic [31:0] res_r;
    logic        commit;
    logic        unused_working;

    // The divider's busy flag is informational only; our own FSM tracks it.
    assign unused_working = div_working;

    assign div_en     = (state == IDLE) && req_valid && !flush;
    assign div_cancel = (state == BUSY) && flush;
    assign div_stall  = req_valid && (state != DONE);
    assign div_sign   = req_sign;
    assign div_a      = req_a;
    assign div_b      = req_b;
    assign commit     = (state == DONE) && req_advance && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (div_en) state <= BUSY;
                BUSY: begin
                    if (flush)           state <= IDLE;
                    else if (div_finish) state <= DONE;
                end
                DONE: if (flush || req_advance) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q <= 32'd0;
            res_r <= 32'd0;
        end else if ((state == BUSY) && div_finish && !flush) begin
            res_q <= div_q;
            res_r <= div_r;
        end
    end

    // A leaving division's commit overrides an MT write in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            hi <= res_r;
            lo <= res_q;
        end else if (!flush) begin
            if (mthi_we) hi <= mt_wdata;
            if (mtlo_we) lo <= mt_wdata;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: divider stub finishing 17 cycles after div_en, scoreboard on HI/LO updates.
module tb_div_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid, req_sign, req_advance, flush;
    logic [31:0] req_a, req_b;
    logic        mthi_we, mtlo_we;
    logic [31:0] mt_wdata;
    logic        div_stall, div_en, div_sign, div_cancel;
    logic [31:0] div_a, div_b, div_q, div_r;
    logic        div_working, div_finish;
    logic [31:0] hi, lo;

    div_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_sign(req_sign), .req_a(req_a), .req_b(req_b),
        .req_advance(req_advance), .flush(flush),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_wdata(mt_wdata),
        .div_stall(div_stall), .div_en(div_en), .div_sign(div_sign),
        .div_a(div_a), .div_b(div_b), .div_cancel(div_cancel),
        .div_q(div_q), .div_r(div_r), .div_working(div_working), .div_finish(div_finish),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider stub: result comes from the vector table, only valid in the finish cycle.
    logic [31:0] stub_q, stub_r;
    logic        stub_busy;
    logic [4:0]  stub_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 5'd0;
        end else if (div_en) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 5'd1;
        end else if (div_cancel || div_finish) begin
            stub_busy <= 1'b0;
        end else if (stub_busy) begin
            stub_cnt <= stub_cnt + 5'd1;
        end
    end
    assign div_finish  = stub_busy && (stub_cnt == 5'd17);
    assign div_working = stub_busy;
    assign div_q       = div_finish ? stub_q : 32'hBAD0BAD0;
    assign div_r       = div_finish ? stub_r : 32'hBAD1BAD1;

    int n_chk = 0;
    int n_pass = 0;

    function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        else n_pass++;
    endfunction

    function automatic void check1(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, exp);
        else n_pass++;
    endfunction

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t        sbq[$];
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    function automatic void sb_push(logic [31:0] h, logic [31:0] l, int c);
        exp_t e;
        e.hi = h; e.lo = l; e.cyc = c;
        sbq.push_back(e);
        cur_hi = h;
        cur_lo = l;
    endfunction

    // Monitor: every visible HI/LO change must match the next expected update.
    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;
    always @(negedge clk) begin
        if (hi !== prev_hi || lo !== prev_lo) begin
            if (sbq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_hilo @cyc %0d: got hi=%h lo=%h, expected hi=%h lo=%h",
                         cyc, hi, lo, prev_hi, prev_lo);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check32("sb_hi", hi, e.hi);
                check32("sb_lo", lo, e.lo);
                check32("sb_cycle", cyc, e.cyc);
            end
            prev_hi = hi;
            prev_lo = lo;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check1("idle_en", div_en, 1'b0);
            check1("idle_cancel", div_cancel, 1'b0);
            check1("idle_stall", div_stall, 1'b0);
            check32("idle_hi", hi, cur_hi);
            check32("idle_lo", lo, cur_lo);
            tick();
        end
    endtask

    task automatic mt_write(input logic hwe, input logic lwe, input logic [31:0] d, input logic fl);
        mthi_we = hwe; mtlo_we = lwe; mt_wdata = d; flush = fl;
        if (!fl) sb_push(hwe ? d : cur_hi, lwe ? d : cur_lo, cyc + 1);
        tick();
        mthi_we = 1'b0; mtlo_we = 1'b0; flush = 1'b0;
    endtask

    // Called at the start of a cycle; returns at the start of the cycle after the last driven one.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r,
                           input int hold, input int flush_at, input logic mt_commit);
        int c0, n;
        logic [31:0] ph, pl;
        c0 = cyc;
        ph = cur_hi;
        pl = cur_lo;
        req_valid = 1'b1; req_sign = sgn; req_a = a; req_b = b;
        stub_q = q; stub_r = r;
        n = (flush_at >= 0) ? flush_at + 1 : 19 + hold;
        if (flush_at < 0) sb_push(r, q, c0 + 19 + hold);
        for (int k = 0; k < n; k++) begin
            req_advance = (hold == 0) || (k >= 18 + hold);
            flush       = (k == flush_at);
            mthi_we     = mt_commit && (k == 18 + hold);
            mt_wdata    = 32'hDEADBEEF;
            @(negedge clk);
            check1("div_stall", div_stall, k < 18);
            check1("div_en", div_en, k == 0);
            check1("div_cancel", div_cancel, (k == flush_at) && (k >= 1) && (k <= 17));
            if (k == 0) begin
                check1("div_sign", div_sign, sgn);
                check32("div_a", div_a, a);
                check32("div_b", div_b, b);
            end
            if (k >= 18) begin
                check32("held_hi", hi, ph);
                check32("held_lo", lo, pl);
            end
            tick();
        end
        req_advance = 1'b0; flush = 1'b0; mthi_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_sign = 1'b0; req_a = 32'd0; req_b = 32'd0;
        req_advance = 1'b0; flush = 1'b0;
        mthi_we = 1'b0; mtlo_we = 1'b0; mt_wdata = 32'd0;
        stub_q = 32'd0; stub_r = 32'd0;

        @(negedge clk);
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        check1("rst_stall", div_stall, 1'b0);
        check1("rst_en", div_en, 1'b0);
        check1("rst_cancel", div_cancel, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // DIVU 100/7, then back-to-back signed and unsigned -7/2
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, -1, 1'b0);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, -1, 1'b0);
        run_div(1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 0, -1, 1'b0);
        idle(2);

        // Preload via MT; an MT write under flush is dropped
        mt_write(1'b1, 1'b1, 32'hA5A5A5A5, 1'b0);
        mt_write(1'b1, 1'b0, 32'h12345678, 1'b1);
        idle(1);

        // Flush in BUSY, then DIVU 9/3
        run_div(1'b0, 32'd40, 32'd4, 32'd10, 32'd0, 0, 5, 1'b0);
        idle(3);
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, -1, 1'b0);

        // Downstream hold of 4 cycles after finish
        run_div(1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 4, -1, 1'b0);

        // Flush in DONE, flush coincident with finish, MTHI against a commit
        run_div(1'b0, 32'd77, 32'd7, 32'd11, 32'd0, 0, 18, 1'b0);
        run_div(1'b0, 32'd21, 32'd4, 32'd5, 32'd1, 0, 17, 1'b0);
        run_div(1'b0, 32'd31, 32'd7, 32'd4, 32'd3, 2, -1, 1'b1);

        // Reset in cycle 8 of a division
        req_valid = 1'b1; req_sign = 1'b0; req_a = 32'd99; req_b = 32'd5;
        stub_q = 32'd19; stub_r = 32'd4;
        for (int k = 0; k < 8; k++) tick();
        reset = 1'b1;
        req_valid = 1'b0;
        sb_push(32'd0, 32'd0, cyc);
        @(negedge clk);
        check32("mid_rst_hi", hi, 32'd0);
        check32("mid_rst_lo", lo, 32'd0);
        check1("mid_rst_en", div_en, 1'b0);
        check1("mid_rst_cancel", div_cancel, 1'b0);
        tick();
        reset = 1'b0;
        idle(3);

        // Divide by zero commits whatever the divider returns
        run_div(1'b0, 32'h00001000, 32'd0, 32'hFFFFFFFF, 32'h00001000, 0, -1, 1'b0);
        idle(3);

        check32("sb_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
